// File: rtl/jtkicker_lmix.sv
// Priority layer mixer with RGB palette PROMs and blanking-aligned colour pipeline.
// Optional frame-stepped brightness fade is enabled by defining JTKICKER_LMIX_FADE_EN.
module jtkicker_lmix #(
  parameter  int LAYERS  = 2,
  parameter  int PXLW    = 4,
  parameter  int PALSELW = 3,
  parameter  int CW      = 4,
  parameter  int DLY     = 9,
  localparam int LW      = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  localparam int AW      = PALSELW + LW + PXLW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pxl_cen,
  input  logic [PALSELW-1:0]     pal_sel,
  input  logic [LAYERS*PXLW-1:0] pxl_in,
  input  logic [LAYERS*LW-1:0]   prio,
  input  logic [LAYERS-1:0]      gfx_en,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [AW-1:0]          prog_addr,
  input  logic [CW-1:0]          prog_data,
  input  logic [2:0]             prog_en,
  input  logic                   fade_start,
  input  logic                   fade_dir,
  output logic                   fade_busy,
  output logic [CW-1:0]          red,
  output logic [CW-1:0]          green,
  output logic [CW-1:0]          blue,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly
);

  logic [CW-1:0]   r_pal_r [0:(2**AW)-1];
  logic [CW-1:0]   r_pal_g [0:(2**AW)-1];
  logic [CW-1:0]   r_pal_b [0:(2**AW)-1];

  logic [AW-1:0]   r_addr;
  logic [DLY-1:0]  r_hb;
  logic [DLY-1:0]  r_vb;
  logic [3*CW-1:0] r_pipe [DLY-2];

  logic [LW-1:0]   w_win_idx;
  logic [PXLW-1:0] w_win_pxl;
  logic [3*CW-1:0] w_raw;
  logic [CW-1:0]   w_red;
  logic [CW-1:0]   w_green;
  logic [CW-1:0]   w_blue;
  logic            w_show;

  // Walk ranks bottom to top so the topmost opaque rank is the last to assign.
  // A rank whose index matches no layer never becomes opaque.
  always_comb begin
    w_win_idx = prio[(LAYERS-1)*LW +: LW];
    w_win_pxl = '0;
    for (int r = LAYERS-1; r >= 0; r--) begin
      for (int l = 0; l < LAYERS; l++) begin
        if (prio[r*LW +: LW] == LW'(l) && gfx_en[l] &&
            pxl_in[l*PXLW +: PXLW] != '0) begin
          w_win_idx = LW'(l);
          w_win_pxl = pxl_in[l*PXLW +: PXLW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prog_en[0]) r_pal_r[prog_addr] <= prog_data;
    if (prog_en[1]) r_pal_g[prog_addr] <= prog_data;
    if (prog_en[2]) r_pal_b[prog_addr] <= prog_data;
  end

  assign w_raw    = r_pipe[DLY-3];
  assign w_show   = r_hb[DLY-2] && r_vb[DLY-2];
  assign LHBL_dly = r_hb[DLY-1];
  assign LVBL_dly = r_vb[DLY-1];

`ifdef JTKICKER_LMIX_FADE_EN
  typedef enum logic {FADE_IDLE, FADE_RUN} fade_state_t;

  fade_state_t r_state;
  logic [4:0]  r_level;
  logic        r_dir;
  logic        r_lvbl_prev;
  logic        r_busy;

  function automatic logic [CW-1:0] fadeScale(input logic [CW-1:0] c, input logic [4:0] lvl);
    logic [CW+3:0] p;
    p = (CW+4)'(c) * (CW+4)'(lvl);
    return CW'(p >> 4);
  endfunction

  assign w_red     = fadeScale(w_raw[3*CW-1:2*CW], r_level);
  assign w_green   = fadeScale(w_raw[2*CW-1:CW], r_level);
  assign w_blue    = fadeScale(w_raw[CW-1:0], r_level);
  assign fade_busy = r_busy;

  // fade_start is captured on any clk; level steps only on LVBL falling edges seen at pxl_cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FADE_IDLE;
      r_level     <= 5'd16;
      r_dir       <= 1'b0;
      r_lvbl_prev <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (pxl_cen) r_lvbl_prev <= LVBL;
      case (r_state)
        FADE_IDLE: begin
          if (fade_start) begin
            r_state <= FADE_RUN;
            r_busy  <= 1'b1;
            r_dir   <= fade_dir;
            r_level <= fade_dir ? 5'd16 : 5'd0;
          end
        end
        FADE_RUN: begin
          if (pxl_cen && r_lvbl_prev && !LVBL) begin
            if (r_dir) begin
              r_level <= r_level - 5'd1;
              if (r_level == 5'd1) begin
                r_state <= FADE_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_level <= r_level + 5'd1;
              if (r_level == 5'd15) begin
                r_state <= FADE_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
        end
        default: r_state <= FADE_IDLE;
      endcase
    end
  end
`else
  logic w_unused;

  assign w_unused  = ^{fade_start, fade_dir};
  assign w_red     = w_raw[3*CW-1:2*CW];
  assign w_green   = w_raw[2*CW-1:CW];
  assign w_blue    = w_raw[CW-1:0];
  assign fade_busy = 1'b0;
`endif

  // Stage 1 mux register, stage 2 PROM read, then plain delay, final stage blanks and scales.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_hb   <= '0;
      r_vb   <= '0;
      for (int j = 0; j < DLY-2; j++) r_pipe[j] <= '0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else if (pxl_cen) begin
      r_addr    <= {pal_sel, w_win_idx, w_win_pxl};
      r_hb      <= {r_hb[DLY-2:0], LHBL};
      r_vb      <= {r_vb[DLY-2:0], LVBL};
      r_pipe[0] <= {r_pal_r[r_addr], r_pal_g[r_addr], r_pal_b[r_addr]};
      for (int j = 1; j < DLY-2; j++) r_pipe[j] <= r_pipe[j-1];
      red   <= w_show ? w_red   : '0;
      green <= w_show ? w_green : '0;
      blue  <= w_show ? w_blue  : '0;
    end
  end

endmodule
